trigger_capture: RTL and testbench
==================================

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 The module SHALL have parameter DATA_IN_BITS, default 12, meaning the signed sample width.
REQ-002 The module SHALL have parameter ADDRESS_BITS, default 12, meaning the sample-buffer address width; buffer depth is 2**ADDRESS_BITS.
REQ-003 The module SHALL have parameter WINDOW, default 1024, meaning the number of samples per displayed frame.
REQ-004 The module SHALL have parameter PRE_TRIGGER, default 512, meaning the number of samples kept before the trigger, with PRE_TRIGGER < WINDOW.
REQ-005 The module SHALL have parameter AUTO_TIMEOUT, default 4096, meaning the number of ARMED samples before a forced trigger.
REQ-006 Ports SHALL be, in order:
- clock  in  1  single clock, rising-edge.
- resetN  in  1  asynchronous, active-low reset.
- sampleValid  in  1  sampleIn is valid this cycle.
- sampleIn  in  DATA_IN_BITS  signed ADC sample.
- triggerLevel  in  DATA_IN_BITS  signed trigger threshold.
- triggerRising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
- autoTrigger  in  1  enables the timeout-forced trigger.
- drawStarting  in  1  one-cycle pulse from the display at the end of each frame.
- writeEnable  out  1  buffer write strobe.
- writeAddress  out  ADDRESS_BITS  buffer write address.
- writeData  out  DATA_IN_BITS  buffer write data.
- windowStart  out  ADDRESS_BITS  buffer address of the first sample of the captured frame.
- frameReady  out  1  the captured frame is stable and may be read.
- captureState  out  3  current FSM state encoding.

Function
REQ-007 The FSM SHALL have states FILL, ARMED, POST, HOLD and SHOW.
REQ-008 In FILL, ARMED and POST, each sampleValid cycle SHALL produce a write one cycle later: writeEnable=1, writeData=sampleIn, writeAddress=current pointer; the pointer then increments modulo 2**ADDRESS_BITS.
REQ-009 In HOLD and SHOW, writeEnable SHALL be 0 and samples SHALL be dropped.
REQ-010 FILL SHALL go to ARMED once PRE_TRIGGER samples have been written since FILL entry; triggers SHALL be ignored in FILL.
REQ-011 A rising trigger SHALL be prev<triggerLevel and cur>=triggerLevel, compared signed; a falling trigger SHALL be prev>=triggerLevel and cur<triggerLevel. Both samples SHALL be consecutive valid samples.
REQ-012 The prev-valid flag SHALL clear on FILL entry, so the first sample after FILL entry never triggers.
REQ-013 In ARMED, a trigger on a sample SHALL move the FSM to POST, set windowStart = (address of that sample − PRE_TRIGGER) mod 2**ADDRESS_BITS, and count that sample as post-sample 1.
REQ-014 When autoTrigger=1 and AUTO_TIMEOUT samples are written in ARMED with no trigger, the next valid sample SHALL be treated as the trigger sample.
REQ-015 The timeout counter SHALL reset on ARMED entry and saturate.
REQ-016 POST SHALL go to HOLD after WINDOW−PRE_TRIGGER samples, counting the trigger sample, have been written.
REQ-017 HOLD SHALL go to SHOW on the first drawStarting; SHOW SHALL go to FILL on the next drawStarting.
REQ-018 drawStarting SHALL be ignored in FILL, ARMED and POST.
REQ-019 frameReady SHALL be 1 exactly while in HOLD or SHOW, registered.
REQ-020 windowStart SHALL hold its value outside the trigger cycle.
REQ-021 A trigger occurring on the same cycle as the ARMED→POST decision SHALL be taken once; a timeout and a real trigger on the same sample SHALL be equivalent.
REQ-022 Pointer wrap from 2**ADDRESS_BITS−1 to 0 SHALL be seamless, including across windowStart.
REQ-023 captureState SHALL encode FILL=0, ARMED=1, POST=2, HOLD=3, SHOW=4.

Reset
REQ-024 resetN=0 SHALL asynchronously force FILL, pointer=0, all counters=0, windowStart=0, writeEnable=0, writeAddress=0, writeData=0, frameReady=0, prev-valid=0.
REQ-025 Reset asserted mid-capture or mid-display SHALL abandon the frame; release SHALL begin a fresh FILL.

Structure
REQ-026 The state encoding and the default DATA_IN_BITS, ADDRESS_BITS, WINDOW and PRE_TRIGGER SHALL live in a shared package used by trigger_capture and the display path.
REQ-027 Edge detection (prev register, prev-valid flag, comparators) SHALL be a sub-module named trigger_detector.

Verification
REQ-028 Ramp −100..+100 step 1 per valid cycle, level 0, rising -> trigger on sample 0; windowStart = its address − 512; 512 post writes; frameReady=1.
REQ-029 Same ramp with triggerRising=0 -> no trigger; with autoTrigger=1 -> forced trigger after 4096 ARMED samples.
REQ-030 Constant −5 with level 0, autoTrigger=0 -> remains ARMED indefinitely with continuous wrapping writes; frameReady=0.
REQ-031 Start pointer at 3900, trigger -> windowStart=3388, writes wrap 4095→0, last post write at address 315.
REQ-032 In HOLD: sampleValid held 1 -> no writes; first drawStarting -> SHOW; second -> FILL; frameReady drops the cycle after.
REQ-033 resetN pulsed low during POST -> all outputs zero immediately; after release, 512 FILL writes starting at address 0.

Source files
------------

// File: rtl/trigger_capture_pkg.sv
// +--------------------------------------------------------------------+
// | trigger_capture_pkg : shared capture-state encoding and defaults   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package trigger_capture_pkg;

    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_SHOW  = 3'd4
    } capture_state_t;

    localparam int TC_DATA_IN_BITS = 12;
    localparam int TC_ADDRESS_BITS = 12;
    localparam int TC_WINDOW       = 1024;
    localparam int TC_PRE_TRIGGER  = 512;
    localparam int TC_AUTO_TIMEOUT = 4096;

    // A frame may be read by the display only while it is frozen.
    function automatic logic frame_visible(input capture_state_t s);
        return (s == ST_HOLD) || (s == ST_SHOW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/trigger_capture_trigger_detector.sv
// +--------------------------------------------------------------------+
// | trigger_detector : level-crossing detector on consecutive samples  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module trigger_detector #(
    parameter int DATA_IN_BITS = 12
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_accept,
    input  logic                           i_clear,
    input  logic signed [DATA_IN_BITS-1:0] i_sample,
    input  logic signed [DATA_IN_BITS-1:0] i_level,
    input  logic                           i_rising,
    output logic                           o_trigger
);

    logic signed [DATA_IN_BITS-1:0] r_prev;
    logic                           r_prev_valid;
    logic                           w_prev_below;
    logic                           w_cur_below;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_clear) begin
            r_prev_valid <= 1'b0;
        end else if (i_accept) begin
            r_prev       <= i_sample;
            r_prev_valid <= 1'b1;
        end
    end

    assign w_prev_below = (r_prev < i_level);
    assign w_cur_below  = (i_sample < i_level);

    // Only an accepted sample with a valid predecessor can form an edge.
    assign o_trigger = i_accept && r_prev_valid &&
                       (i_rising ? (w_prev_below && !w_cur_below)
                                 : (!w_prev_below && w_cur_below));

endmodule

`default_nettype wire

// File: rtl/trigger_capture.sv
// +--------------------------------------------------------------------+
// | trigger_capture : pre/post-trigger sample capture into ring buffer |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module trigger_capture
    import trigger_capture_pkg::*;
#(
    parameter int DATA_IN_BITS = TC_DATA_IN_BITS,
    parameter int ADDRESS_BITS = TC_ADDRESS_BITS,
    parameter int WINDOW       = TC_WINDOW,
    parameter int PRE_TRIGGER  = TC_PRE_TRIGGER,
    parameter int AUTO_TIMEOUT = TC_AUTO_TIMEOUT
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic                           sampleValid,
    input  logic signed [DATA_IN_BITS-1:0] sampleIn,
    input  logic signed [DATA_IN_BITS-1:0] triggerLevel,
    input  logic                           triggerRising,
    input  logic                           autoTrigger,
    input  logic                           drawStarting,
    output logic                           writeEnable,
    output logic [ADDRESS_BITS-1:0]        writeAddress,
    output logic [DATA_IN_BITS-1:0]        writeData,
    output logic [ADDRESS_BITS-1:0]        windowStart,
    output logic                           frameReady,
    output logic [2:0]                     captureState
);

    localparam int CW       = $clog2(WINDOW + 1);
    localparam int TW       = $clog2(AUTO_TIMEOUT + 1);
    localparam int POST_LEN = WINDOW - PRE_TRIGGER;

    localparam logic [CW-1:0]           c_pre_last    = CW'(PRE_TRIGGER - 1);
    localparam logic [CW-1:0]           c_post_last   = CW'(POST_LEN - 1);
    localparam logic [TW-1:0]           c_timeout_max = TW'(AUTO_TIMEOUT);
    localparam logic [ADDRESS_BITS-1:0] c_pre_offset  = ADDRESS_BITS'(PRE_TRIGGER);

    capture_state_t                r_state;
    capture_state_t                w_next;
    logic [ADDRESS_BITS-1:0]       r_ptr;
    logic [CW-1:0]                 r_count;
    logic [TW-1:0]                 r_timeout;
    logic [ADDRESS_BITS-1:0]       r_window_start;
    logic                          r_we;
    logic [ADDRESS_BITS-1:0]       r_wa;
    logic [DATA_IN_BITS-1:0]       r_wd;
    logic                          r_frame_ready;

    logic w_accept;
    logic w_edge;
    logic w_timeout;
    logic w_fire;
    logic w_clear;

    assign w_accept  = sampleValid &&
                       ((r_state == ST_FILL) || (r_state == ST_ARMED) || (r_state == ST_POST));
    assign w_timeout = autoTrigger && (r_timeout == c_timeout_max);
    assign w_fire    = w_accept && (r_state == ST_ARMED) && (w_edge || w_timeout);
    assign w_clear   = (r_state == ST_SHOW) && drawStarting;

    trigger_detector #(
        .DATA_IN_BITS (DATA_IN_BITS)
    ) u_trigger_detector (
        .clk       (clock),
        .rst_n     (resetN),
        .i_accept  (w_accept),
        .i_clear   (w_clear),
        .i_sample  (sampleIn),
        .i_level   (triggerLevel),
        .i_rising  (triggerRising),
        .o_trigger (w_edge)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FILL:  if (w_accept && (r_count == c_pre_last)) w_next = ST_ARMED;
            ST_ARMED: if (w_fire) w_next = (POST_LEN == 1) ? ST_HOLD : ST_POST;
            ST_POST:  if (w_accept && (r_count == c_post_last)) w_next = ST_HOLD;
            ST_HOLD:  if (drawStarting) w_next = ST_SHOW;
            ST_SHOW:  if (drawStarting) w_next = ST_FILL;
            default:  w_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state        <= ST_FILL;
            r_ptr          <= '0;
            r_count        <= '0;
            r_timeout      <= '0;
            r_window_start <= '0;
            r_we           <= 1'b0;
            r_wa           <= '0;
            r_wd           <= '0;
            r_frame_ready  <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_frame_ready <= frame_visible(w_next);
            r_we          <= w_accept;
            if (w_accept) begin
                r_wa  <= r_ptr;
                r_wd  <= sampleIn;
                r_ptr <= r_ptr + ADDRESS_BITS'(1);
            end

            // One counter serves both FILL (pre samples) and POST (post samples);
            // the trigger sample itself is post-sample 1.
            if (r_state != w_next) begin
                r_count <= (w_next == ST_POST) ? CW'(1) : '0;
            end else if (w_accept && ((r_state == ST_FILL) || (r_state == ST_POST))) begin
                r_count <= r_count + CW'(1);
            end

            if (r_state != ST_ARMED) begin
                r_timeout <= '0;
            end else if (w_accept && !w_fire && (r_timeout != c_timeout_max)) begin
                r_timeout <= r_timeout + TW'(1);
            end

            if (w_fire) begin
                r_window_start <= r_ptr - c_pre_offset;
            end
        end
    end

    assign writeEnable  = r_we;
    assign writeAddress = r_wa;
    assign writeData    = r_wd;
    assign windowStart  = r_window_start;
    assign frameReady   = r_frame_ready;
    assign captureState = r_state;

endmodule

`default_nettype wire

// File: tb/tb_trigger_capture.sv
// +--------------------------------------------------------------------+
// | tb_trigger_capture : directed bench with a per-sample reference    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_trigger_capture;

    localparam int DW       = 12;
    localparam int AW       = 12;
    localparam int DEPTH    = 4096;
    localparam int WIN      = 1024;
    localparam int PRE      = 512;
    localparam int AUTO     = 4096;
    localparam int POST_LEN = WIN - PRE;

    logic                 clock = 1'b0;
    logic                 resetN;
    logic                 sampleValid;
    logic signed [DW-1:0] sampleIn;
    logic signed [DW-1:0] triggerLevel;
    logic                 triggerRising;
    logic                 autoTrigger;
    logic                 drawStarting;
    logic                 writeEnable;
    logic [AW-1:0]        writeAddress;
    logic signed [DW-1:0] writeData;
    logic [AW-1:0]        windowStart;
    logic                 frameReady;
    logic [2:0]           captureState;

    int n_total = 0;
    int n_bad   = 0;

    trigger_capture #(
        .DATA_IN_BITS (DW),
        .ADDRESS_BITS (AW),
        .WINDOW       (WIN),
        .PRE_TRIGGER  (PRE),
        .AUTO_TIMEOUT (AUTO)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .sampleValid   (sampleValid),
        .sampleIn      (sampleIn),
        .triggerLevel  (triggerLevel),
        .triggerRising (triggerRising),
        .autoTrigger   (autoTrigger),
        .drawStarting  (drawStarting),
        .writeEnable   (writeEnable),
        .writeAddress  (writeAddress),
        .writeData     (writeData),
        .windowStart   (windowStart),
        .frameReady    (frameReady),
        .captureState  (captureState)
    );

    always #5 clock = ~clock;

    // Reference: phase 0..4 = fill/armed/post/hold/show, tracked per accepted sample.
    int m_phase = 0, m_ptr = 0, m_n = 0, m_armed = 0, m_prev = 0;
    bit m_prev_ok = 0;
    int e_we = 0, e_wa = 0, e_wd = 0, e_ws = 0;
    int s_cur, s_lvl;
    bit hit;

    initial forever begin
        @(posedge clock or negedge resetN);
        if (!resetN) begin
            m_phase = 0; m_ptr = 0; m_n = 0; m_armed = 0; m_prev = 0; m_prev_ok = 0;
            e_we = 0; e_wa = 0; e_wd = 0; e_ws = 0;
        end else begin
            e_we = 0;
            if (sampleValid && m_phase <= 2) begin
                s_cur = sampleIn;
                s_lvl = triggerLevel;
                hit = m_prev_ok && (triggerRising ? (m_prev < s_lvl && s_cur >= s_lvl)
                                                  : (m_prev >= s_lvl && s_cur < s_lvl));
                e_we = 1; e_wa = m_ptr; e_wd = s_cur;
                m_prev = s_cur; m_prev_ok = 1;
                if (m_phase == 0) begin
                    m_n++;
                    if (m_n == PRE) begin m_phase = 1; m_armed = 0; end
                end else if (m_phase == 1) begin
                    if (hit || (autoTrigger && m_armed >= AUTO)) begin
                        e_ws = (m_ptr - PRE + DEPTH) % DEPTH;
                        m_n = 1;
                        m_phase = (m_n == POST_LEN) ? 3 : 2;
                    end else if (m_armed < AUTO) begin
                        m_armed++;
                    end
                end else begin
                    m_n++;
                    if (m_n == POST_LEN) m_phase = 3;
                end
                m_ptr = (m_ptr + 1) % DEPTH;
            end else if (drawStarting && m_phase == 3) begin
                m_phase = 4;
            end else if (drawStarting && m_phase == 4) begin
                m_phase = 0; m_n = 0; m_prev_ok = 0;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        n_total++;
        if (int'(writeEnable) != e_we || int'(writeAddress) != e_wa ||
            int'(writeData) != e_wd || int'(windowStart) != e_ws ||
            int'(frameReady) != (m_phase >= 3 ? 1 : 0) || int'(captureState) != m_phase) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t: got we=%0d wa=%0d wd=%0d ws=%0d fr=%0d st=%0d want we=%0d wa=%0d wd=%0d ws=%0d fr=%0d st=%0d",
                     $time, writeEnable, writeAddress, writeData, windowStart, frameReady, captureState,
                     e_we, e_wa, e_wd, e_ws, (m_phase >= 3 ? 1 : 0), m_phase);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input bit v, input int s, input bit d);
        sampleValid  = v;
        sampleIn     = s[DW-1:0];
        drawStarting = d;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        resetN = 1'b0;
        @(posedge clock);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0; sampleValid = 1'b0; sampleIn = '0; triggerLevel = '0;
        triggerRising = 1'b1; autoTrigger = 1'b0; drawStarting = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_we", int'(writeEnable), 0);
        chk("rst_wa", int'(writeAddress), 0);
        chk("rst_ws", int'(windowStart), 0);
        chk("rst_fr", int'(frameReady), 0);
        chk("rst_state", int'(captureState), 0);
        resetN = 1'b1;

        // Rising ramp: fill at 0..511, ramp from 512, zero crossing at 612.
        repeat (PRE) cyc(1, -100, 0);
        chk("fill_done_state", int'(captureState), 1);
        chk("fill_last_addr", int'(writeAddress), 511);
        for (int v = -100; v <= -1; v++) cyc(1, v, 0);
        chk("pre_trig_state", int'(captureState), 1);
        cyc(1, 0, 0);
        chk("trig_state", int'(captureState), 2);
        chk("trig_ws", int'(windowStart), 100);
        chk("trig_wa", int'(writeAddress), 612);
        for (int v = 1; v <= 100; v++) cyc(1, v, 0);
        repeat (410) cyc(1, 100, 0);
        chk("post_not_done", int'(captureState), 2);
        cyc(1, 100, 0);
        chk("hold_state", int'(captureState), 3);
        chk("hold_fr", int'(frameReady), 1);
        chk("last_post_wa", int'(writeAddress), 1123);

        // Frozen frame ignores samples, then two draw pulses release it.
        repeat (5) cyc(1, 7, 0);
        chk("hold_no_write", int'(writeEnable), 0);
        chk("hold_wa_kept", int'(writeAddress), 1123);
        cyc(1, 7, 1);
        chk("show_state", int'(captureState), 4);
        chk("show_fr", int'(frameReady), 1);
        repeat (3) cyc(1, 7, 0);
        cyc(0, 0, 1);
        chk("refill_state", int'(captureState), 0);
        chk("refill_fr", int'(frameReady), 0);

        // Falling mode on a rising ramp never triggers; the timeout forces it.
        triggerRising = 1'b0; autoTrigger = 1'b1;
        cyc(1, -100, 1);
        chk("draw_ignored_fill", int'(captureState), 0);
        repeat (PRE - 1) cyc(1, -100, 0);
        chk("auto_fill_done", int'(captureState), 1);
        chk("auto_fill_wa", int'(writeAddress), 1635);
        for (int v = -100; v <= 100; v++) cyc(1, v, 0);
        repeat (AUTO - 201) cyc(1, 100, 0);
        chk("auto_still_armed", int'(captureState), 1);
        cyc(1, 100, 0);
        chk("auto_state", int'(captureState), 2);
        chk("auto_ws", int'(windowStart), 1124);
        chk("auto_wa", int'(writeAddress), 1636);
        repeat (POST_LEN - 1) cyc(1, 100, 0);
        chk("auto_hold", int'(captureState), 3);

        // Constant below level stays armed and wraps; then trigger at 3900.
        triggerRising = 1'b1; autoTrigger = 1'b0;
        pulse_reset();
        repeat (PRE) cyc(1, -5, 0);
        repeat (3388 + DEPTH) cyc(1, -5, 0);
        chk("const_armed", int'(captureState), 1);
        chk("const_fr", int'(frameReady), 0);
        chk("const_wa", int'(writeAddress), 3899);
        cyc(1, 0, 0);
        chk("wrap_trig_ws", int'(windowStart), 3388);
        chk("wrap_trig_wa", int'(writeAddress), 3900);
        for (int i = 1; i < POST_LEN; i++) begin
            cyc(1, 0, 0);
            if (i == 195) chk("wrap_top", int'(writeAddress), 4095);
            if (i == 196) chk("wrap_zero", int'(writeAddress), 0);
        end
        chk("wrap_last_wa", int'(writeAddress), 315);
        chk("wrap_hold", int'(captureState), 3);

        // Reset during POST abandons the frame; refill starts at address 0.
        pulse_reset();
        repeat (PRE) cyc(1, -100, 0);
        for (int v = -100; v <= 0; v++) cyc(1, v, 0);
        repeat (100) cyc(1, 5, 0);
        chk("pre_rst_post", int'(captureState), 2);
        resetN = 1'b0;
        #1;
        chk("midrst_we", int'(writeEnable), 0);
        chk("midrst_wa", int'(writeAddress), 0);
        chk("midrst_wd", int'(writeData), 0);
        chk("midrst_ws", int'(windowStart), 0);
        chk("midrst_state", int'(captureState), 0);
        @(posedge clock);
        #1;
        resetN = 1'b1;
        cyc(1, 3, 0);
        chk("refill_first_wa", int'(writeAddress), 0);
        chk("refill_first_we", int'(writeEnable), 1);
        repeat (PRE - 1) cyc(1, 3, 0);
        chk("refill_last_wa", int'(writeAddress), 511);
        chk("refill_armed", int'(captureState), 1);

        cyc(0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
